// File: rtl/hazard_pkg.sv
// Shared types and defaults for the RV32 pipeline hazard unit.
// Imported by hazard_ctrl and hazard_mc_ctrl.
package hazard_pkg;

  localparam int REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_mc_ctrl.sv
// Multi-cycle EX occupancy FSM: holds E for MC_LAT cycles.
// Outputs are forced low while rst is high.
module hazard_mc_ctrl
  import hazard_pkg::*;
#(
  parameter int MC_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic mc_op_e,
  input  logic pcsrc_e,
  output logic mc_stall,
  output logic busy,
  output logic mc_done_e
);

  localparam int CW = (MC_LAT <= 2) ? 1 : $clog2(MC_LAT);
  localparam bit MULTI = (MC_LAT >= 2);
  localparam logic [CW-1:0] CNT_INIT =
    CW'((MC_LAT >= 2) ? MC_LAT - 2 : 0);

  hz_state_t     state;
  logic [CW-1:0] cnt;
  logic          start;

  // A taken branch in IDLE squashes the op, so it never starts
  assign start = MULTI && mc_op_e && !pcsrc_e;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= BUSY;
            cnt   <= CNT_INIT;
          end
        end
        BUSY: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mc_stall  = 1'b0;
    busy      = 1'b0;
    mc_done_e = 1'b0;
    if (!rst) begin
      busy = (state == BUSY);
      if (state == IDLE) begin
        mc_stall  = start;
        mc_done_e = MULTI ? 1'b0 : mc_op_e;
      end else begin
        mc_stall  = (cnt != '0);
        mc_done_e = (cnt == '0);
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard unit for the 5-stage RV32 core: forwarding, load-use, flush, mc stall.
// Optional HAZARD_STATS_EN adds saturating stall/flush statistics counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int MC_LAT = 4
`ifdef HAZARD_STATS_EN
  ,
  parameter int STAT_W = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  input  logic              mem_read_e,
  input  logic              pcsrc_e,
  input  logic              mc_op_e,
  output logic [1:0]        forward_a_e,
  output logic [1:0]        forward_b_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic              busy,
  output logic              mc_done_e
`ifdef HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_cycles,
  output logic [STAT_W-1:0] flush_events
`endif
);

  fwd_sel_t fa;
  fwd_sel_t fb;
  logic     lu;
  logic     mc_stall;
  logic     br;

  hazard_mc_ctrl #(
    .MC_LAT(MC_LAT)
  ) u_mc (
    .clk      (clk),
    .rst      (rst),
    .mc_op_e  (mc_op_e),
    .pcsrc_e  (pcsrc_e),
    .mc_stall (mc_stall),
    .busy     (busy),
    .mc_done_e(mc_done_e)
  );

  always_comb begin
    fa = FWD_REG;
    if (reg_write_m && rd_m == rs1_e && rd_m != '0)
      fa = FWD_M;
    else if (reg_write_w && rd_w == rs1_e && rd_w != '0)
      fa = FWD_W;
  end

  always_comb begin
    fb = FWD_REG;
    if (reg_write_m && rd_m == rs2_e && rd_m != '0)
      fb = FWD_M;
    else if (reg_write_w && rd_w == rs2_e && rd_w != '0)
      fb = FWD_W;
  end

  assign forward_a_e = fa;
  assign forward_b_e = fb;

  assign lu = mem_read_e && rd_e != '0 &&
              (rd_e == rs1_d || rd_e == rs2_d);

  // Branch resolution is ignored while a multi-cycle op holds E
  assign br = pcsrc_e && !busy;

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    if (rst) begin
      stall_f = 1'b0;
    end else if (br) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (mc_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      flush_m = 1'b1;
    end else if (lu) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

`ifdef HAZARD_STATS_EN
  logic any_flush;
  assign any_flush = flush_d | flush_e | flush_m;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall_f && !(&stall_cycles))
        stall_cycles <= stall_cycles + STAT_W'(1);
      if (any_flush && !(&flush_events))
        flush_events <= flush_events + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MC_LAT=4).
// Control vector order: stall_f,stall_d,stall_e,flush_d,flush_e,flush_m,busy,mc_done_e.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       reg_write_m, reg_write_w, mem_read_e, pcsrc_e, mc_op_e;
  logic [1:0] forward_a_e, forward_b_e;
  logic       stall_f, stall_d, stall_e;
  logic       flush_d, flush_e, flush_m, busy, mc_done_e;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .REG_AW(5),
    .MC_LAT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rs1_d      (rs1_d),
    .rs2_d      (rs2_d),
    .rs1_e      (rs1_e),
    .rs2_e      (rs2_e),
    .rd_e       (rd_e),
    .rd_m       (rd_m),
    .rd_w       (rd_w),
    .reg_write_m(reg_write_m),
    .reg_write_w(reg_write_w),
    .mem_read_e (mem_read_e),
    .pcsrc_e    (pcsrc_e),
    .mc_op_e    (mc_op_e),
    .forward_a_e(forward_a_e),
    .forward_b_e(forward_b_e),
    .stall_f    (stall_f),
    .stall_d    (stall_d),
    .stall_e    (stall_e),
    .flush_d    (flush_d),
    .flush_e    (flush_e),
    .flush_m    (flush_m),
    .busy       (busy),
    .mc_done_e  (mc_done_e)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_events(flush_events)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ctl();
    return {stall_f, stall_d, stall_e, flush_d,
            flush_e, flush_m, busy, mc_done_e};
  endfunction

  task automatic clear_in();
    {rs1_d, rs2_d, rs1_e, rs2_e} = '0;
    {rd_e, rd_m, rd_w} = '0;
    {reg_write_m, reg_write_w, mem_read_e, pcsrc_e, mc_op_e} = '0;
  endtask

  initial begin
    clear_in();
    rs1_e = 5'd3;
    mc_op_e = 1'b1;
    #2;
    check("reset_ctl", 32'(ctl()), 32'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_in();
    #1;
    check("idle_ctl", 32'(ctl()), 32'h00);

    // forwarding
    reg_write_m = 1; rd_m = 5; reg_write_w = 1; rd_w = 5;
    rs1_e = 5; rs2_e = 6;
    #1;
    check("fwd_a_m_beats_w", 32'(forward_a_e), 32'h2);
    check("fwd_b_none", 32'(forward_b_e), 32'h0);
    reg_write_m = 0;
    #1;
    check("fwd_a_w", 32'(forward_a_e), 32'h1);
    rd_w = 6; rd_m = 6; reg_write_m = 1;
    #1;
    check("fwd_b_m", 32'(forward_b_e), 32'h2);
    check("fwd_a_none", 32'(forward_a_e), 32'h0);
    clear_in();
    reg_write_m = 1; reg_write_w = 1;
    #1;
    check("fwd_x0_guard", 32'({forward_a_e, forward_b_e}), 32'h0);

    // load-use
    @(negedge clk);
    clear_in();
    mem_read_e = 1; rd_e = 7; rs2_d = 7;
    #1;
    check("lu_ctl", 32'(ctl()), 32'hC8);
    @(negedge clk);
    mem_read_e = 0;
    #1;
    check("lu_release", 32'(ctl()), 32'h00);
    mem_read_e = 1; rd_e = 0; rs1_d = 0; rs2_d = 0;
    #1;
    check("lu_x0", 32'(ctl()), 32'h00);

    // branch over load-use
    rd_e = 7; rs2_d = 7; pcsrc_e = 1;
    #1;
    check("br_over_lu", 32'(ctl()), 32'h18);

    // branch suppresses mc start
    @(negedge clk);
    clear_in();
    pcsrc_e = 1; mc_op_e = 1;
    #1;
    check("br_over_mc", 32'(ctl()), 32'h18);
    @(negedge clk);
    clear_in();
    #1;
    check("br_no_busy", 32'(ctl()), 32'h00);

    // fresh counters for the mc sequence
    rst = 1;
    @(negedge clk);
    rst = 0;

    mc_op_e = 1;
    #1;
    check("mc_c1", 32'(ctl()), 32'hE4);
    @(negedge clk);
    #1;
    check("mc_c2", 32'(ctl()), 32'hE6);
    @(negedge clk);
    pcsrc_e = 1;
    #1;
    check("mc_c3_br_ignored", 32'(ctl()), 32'hE6);
    @(negedge clk);
    pcsrc_e = 0;
    #1;
    check("mc_c4_done", 32'(ctl()), 32'h03);
    @(negedge clk);
    mc_op_e = 0;
    #1;
    check("mc_c5_idle", 32'(ctl()), 32'h00);
`ifdef HAZARD_STATS_EN
    check("stat_stall", stall_cycles, 32'd3);
    check("stat_flush", flush_events, 32'd3);
`endif

    // reset mid-op
    @(negedge clk);
    mc_op_e = 1;
    @(negedge clk);
    #1;
    check("rmo_busy", 32'(ctl()), 32'hE6);
    rst = 1;
    #1;
    check("rmo_reset", 32'(ctl()), 32'h00);
`ifdef HAZARD_STATS_EN
    check("stat_clr", stall_cycles | flush_events, 32'd0);
`endif
    @(negedge clk);
    rst = 0;
    #1;
    check("rmo_c1", 32'(ctl()), 32'hE4);
    @(negedge clk);
    #1;
    check("rmo_c2", 32'(ctl()), 32'hE6);
    @(negedge clk);
    #1;
    check("rmo_c3", 32'(ctl()), 32'hE6);
    @(negedge clk);
    #1;
    check("rmo_c4_done", 32'(ctl()), 32'h03);
    @(negedge clk);
    mc_op_e = 0;
    #1;
    check("rmo_c5_idle", 32'(ctl()), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
